// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and the datapath (slave).
// The datapath and memory drive the decode fields and handshakes; the controller drives the rest.
interface mips_mc_ctrl_if #(
  parameter int unsigned COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mdr_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_ctl;
  logic [1:0]         pc_source;
  logic               halted;
  logic [1:0]         err_code;
  logic [COUNT_W-1:0] cycle_count;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source, halted, err_code,
           cycle_count, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source, halted, err_code,
           cycle_count, instr_count
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing a shared memory, IR, PC, ALU and
// register file, with memory wait-state timeout, halt causes and cycle/retire counters.
module mips_mc_ctrl #(
  parameter int unsigned COUNT_W = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic            CLK,
  input logic            reset,
  mips_mc_ctrl_if.master bus
);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StRtype, StRwb, StMemAdr, StMemRd, StMemWb, StMemWr,
    StBranch, StAddiEx, StAddiWb, StJump, StHalt
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [1:0]         err_q, err_d;
  logic [COUNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic               mem_wait, timeout, rtype_ok, retire;
  logic [2:0]         rtype_ctl;

  always_comb begin
    rtype_ctl = AluAdd;
    rtype_ok  = 1'b1;
    case (bus.funct)
      6'h20:   rtype_ctl = AluAdd;
      6'h22:   rtype_ctl = AluSub;
      6'h24:   rtype_ctl = AluAnd;
      6'h25:   rtype_ctl = AluOr;
      6'h2A:   rtype_ctl = AluSlt;
      default: rtype_ok  = 1'b0;
    endcase
  end

  assign mem_wait = state_q inside {StFetch, StMemRd, StMemWr};
  // Ready arriving on the last allowed wait cycle still counts as completion.
  assign timeout  = mem_wait && !bus.mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (bus.mem_ready) state_d = StDecode;
        else if (timeout) begin
          state_d = StHalt;
          err_d   = 2'b11;
        end
      end
      StDecode: begin
        unique case (bus.opcode)
          6'h23, 6'h2B: state_d = StMemAdr;
          6'h04:        state_d = StBranch;
          6'h08:        state_d = StAddiEx;
          6'h02:        state_d = StJump;
          6'h00: begin
            if (bus.funct == 6'h0C) begin
              state_d = StHalt;
              err_d   = 2'b01;
            end else begin
              state_d = StRtype;
            end
          end
          default: begin
            state_d = StHalt;
            err_d   = 2'b10;
          end
        endcase
      end
      StRtype: begin
        if (rtype_ok) state_d = StRwb;
        else begin
          state_d = StHalt;
          err_d   = 2'b10;
        end
      end
      StMemAdr: state_d = (bus.opcode == 6'h23) ? StMemRd : StMemWr;
      StMemRd: begin
        if (bus.mem_ready) state_d = StMemWb;
        else if (timeout) begin
          state_d = StHalt;
          err_d   = 2'b11;
        end
      end
      StMemWr: begin
        if (bus.mem_ready) state_d = StFetch;
        else if (timeout) begin
          state_d = StHalt;
          err_d   = 2'b11;
        end
      end
      StAddiEx: state_d = StAddiWb;
      StRwb, StMemWb, StBranch, StAddiWb, StJump: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    retire  = (state_d == StFetch) &&
              (state_q inside {StRwb, StMemWb, StMemWr, StBranch, StAddiWb, StJump});
    instr_d = retire ? instr_q + COUNT_W'(1) : instr_q;
    cycle_d = (state_q inside {StIdle, StHalt}) ? cycle_q : cycle_q + COUNT_W'(1);
    wait_d  = (state_d != state_q || !mem_wait || bus.mem_ready) ? 8'd0 : wait_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
      err_q   <= 2'b00;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mdr_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctl    = 3'b000;
    bus.pc_source  = 2'b00;
    unique case (state_q)
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_ctl   = AluAdd;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
      end
      StDecode: begin
        bus.alu_src_b = 2'b11;
        bus.alu_ctl   = AluAdd;
      end
      StRtype: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctl   = rtype_ctl;
      end
      StRwb: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      StMemAdr, StAddiEx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctl   = AluAdd;
      end
      StMemRd: begin
        bus.mem_read  = 1'b1;
        bus.iord      = 1'b1;
        bus.mdr_write = bus.mem_ready;
      end
      StMemWb: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      StMemWr: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctl   = AluSub;
        bus.pc_source = 2'b01;
        bus.pc_en     = bus.zero;
      end
      StAddiWb: bus.reg_write = 1'b1;
      StJump: begin
        bus.pc_source = 2'b10;
        bus.pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.halted      = (state_q == StHalt);
  assign bus.err_code    = err_q;
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a table of single-instruction runs with ready tied high,
// then hand-written wait-state, timeout and mid-instruction reset sequences.
module tb_mips_mc_ctrl;
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  mips_mc_ctrl_if #(.COUNT_W(32)) bus ();
  mips_mc_ctrl #(.COUNT_W(32), .TIMEOUT(16)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         k;
    logic       halt;
    logic [1:0] err;
    int         instr;
    int         cyc;
    int         rw;
    int         pce;
    logic       chk_alu;
    logic [2:0] alu;
  } vec_t;

  vec_t       vecs[16];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         rw_cnt, pce_cnt, ir_cnt, mdr_cnt;
  logic [2:0] exec_alu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [19:0] ctl_bus();
    return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.mdr_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_ctl, bus.pc_source, bus.halted, bus.err_code};
  endfunction

  task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic z);
    reset         = 1'b0;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset    = 1'b1;
    rw_cnt   = 0;
    pce_cnt  = 0;
    ir_cnt   = 0;
    mdr_cnt  = 0;
    exec_alu = 3'b011;
  endtask

  // One clock; ready is applied just after the edge so it belongs to the new state.
  task automatic step(input logic rdy);
    @(posedge CLK);
    #1 bus.mem_ready = rdy;
    @(negedge CLK);
    if (bus.reg_write) rw_cnt++;
    if (bus.pc_en) pce_cnt++;
    if (bus.ir_write) ir_cnt++;
    if (bus.mdr_write) mdr_cnt++;
    if (bus.alu_src_a) exec_alu = bus.alu_ctl;
  endtask

  initial begin
    //           op     fn     z     k   halt  err    in cy rw pce chk   alu
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b010};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b110};
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b000};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b001};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b111};
    vecs[5]  = '{6'h23, 6'h00, 1'b0, 6,  1'b0, 2'b00, 1, 5, 1, 2, 1'b1, 3'b010};
    vecs[6]  = '{6'h2B, 6'h00, 1'b0, 5,  1'b0, 2'b00, 1, 4, 0, 2, 1'b1, 3'b010};
    vecs[7]  = '{6'h04, 6'h00, 1'b1, 4,  1'b0, 2'b00, 1, 3, 0, 3, 1'b1, 3'b110};
    vecs[8]  = '{6'h04, 6'h00, 1'b0, 4,  1'b0, 2'b00, 1, 3, 0, 2, 1'b1, 3'b110};
    vecs[9]  = '{6'h08, 6'h00, 1'b0, 5,  1'b0, 2'b00, 1, 4, 1, 2, 1'b1, 3'b010};
    vecs[10] = '{6'h02, 6'h00, 1'b0, 4,  1'b0, 2'b00, 1, 3, 0, 3, 1'b1, 3'b011};
    vecs[11] = '{6'h00, 6'h0C, 1'b0, 3,  1'b1, 2'b01, 0, 2, 0, 1, 1'b1, 3'b011};
    vecs[12] = '{6'h00, 6'h0C, 1'b0, 25, 1'b1, 2'b01, 0, 2, 0, 1, 1'b1, 3'b011};
    vecs[13] = '{6'h3F, 6'h00, 1'b0, 6,  1'b1, 2'b10, 0, 2, 0, 1, 1'b1, 3'b011};
    vecs[14] = '{6'h00, 6'h03, 1'b0, 8,  1'b1, 2'b10, 0, 3, 0, 1, 1'b0, 3'b000};
    vecs[15] = '{6'h00, 6'h20, 1'b1, 3,  1'b0, 2'b00, 0, 2, 0, 1, 1'b1, 3'b010};

    reset         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("reset_ctl", 32'(ctl_bus()), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold_ctl", 32'(ctl_bus()), 32'd0);
    check("reset_cycle", bus.cycle_count, 32'd0);
    check("reset_instr", bus.instr_count, 32'd0);

    for (int i = 0; i < 16; i++) begin
      start(vecs[i].op, vecs[i].fn, vecs[i].z);
      for (int c = 0; c < vecs[i].k; c++) step(1'b1);
      check($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(vecs[i].halt));
      check($sformatf("v%0d_err", i), 32'(bus.err_code), 32'(vecs[i].err));
      check($sformatf("v%0d_instr", i), bus.instr_count, 32'(vecs[i].instr));
      check($sformatf("v%0d_cycle", i), bus.cycle_count, 32'(vecs[i].cyc));
      check($sformatf("v%0d_regwr", i), 32'(rw_cnt), 32'(vecs[i].rw));
      check($sformatf("v%0d_pcen", i), 32'(pce_cnt), 32'(vecs[i].pce));
      if (vecs[i].chk_alu) check($sformatf("v%0d_alu", i), 32'(exec_alu), 32'(vecs[i].alu));
    end

    // lw with three wait cycles in both FETCH and MEMRD
    start(6'h23, 6'h00, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      step(!(j inside {1, 2, 3, 7, 8, 9, 12}));
      if (j == 2) check("lw_fetch_wait", 32'({bus.mem_read, bus.iord, bus.ir_write}), 32'b100);
      if (j == 4) check("lw_ir_write", 32'(bus.ir_write), 32'd1);
      if (j == 8) check("lw_memrd_wait", 32'({bus.mem_read, bus.iord, bus.mdr_write}), 32'b110);
      if (j == 10) check("lw_mdr_write", 32'(bus.mdr_write), 32'd1);
    end
    check("lw_ir_once", 32'(ir_cnt), 32'd1);
    check("lw_mdr_once", 32'(mdr_cnt), 32'd1);
    check("lw_back_fetch", 32'(bus.mem_read), 32'd1);
    check("lw_cycle", bus.cycle_count, 32'd11);
    check("lw_instr", bus.instr_count, 32'd1);

    // ready never arrives in FETCH
    start(6'h23, 6'h00, 1'b0);
    for (int j = 1; j <= 16; j++) step(1'b0);
    check("to_not_yet", 32'(bus.halted), 32'd0);
    step(1'b0);
    check("to_halted", 32'(bus.halted), 32'd1);
    check("to_err", 32'(bus.err_code), 32'd3);
    check("to_cycle", bus.cycle_count, 32'd16);
    repeat (5) step(1'b0);
    check("to_frozen", bus.cycle_count, 32'd16);
    check("to_no_ir", 32'(ir_cnt), 32'd0);

    // ready on the last allowed wait cycle completes the fetch
    start(6'h23, 6'h00, 1'b0);
    for (int j = 1; j <= 16; j++) step(j == 16);
    step(1'b1);
    check("edge_not_halted", 32'(bus.halted), 32'd0);
    check("edge_ir_once", 32'(ir_cnt), 32'd1);
    check("edge_decode", 32'({bus.alu_src_b, bus.mem_read}), 32'b110);

    // reset dropped while sw waits in MEMWR
    start(6'h2B, 6'h00, 1'b0);
    for (int j = 1; j <= 5; j++) step(j < 4);
    check("sw_memwr", 32'({bus.mem_write, bus.iord}), 32'b11);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ctl", 32'(ctl_bus()), 32'd0);
    check("rst_mid_cycle", bus.cycle_count, 32'd0);
    check("rst_mid_instr", bus.instr_count, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("rst_idle_ctl", 32'(ctl_bus()), 32'd0);
    step(1'b1);
    check("rst_refetch", 32'(bus.mem_read), 32'd1);
    check("rst_refetch_cycle", bus.cycle_count, 32'd0);
    step(1'b1);
    check("rst_decode_cycle", bus.cycle_count, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS core. Replaces single-cycle decode with a Moore FSM that sequences one shared byte-addressed memory, the IR, PC, ALU and register file over 3-5 states per instruction.
- Supports memory wait states through a ready handshake.
- Flags halts for syscall, illegal instruction or memory timeout.
- Exposes cycle and retired-instruction counters to the testbench.

Parameters:
- COUNT_W, 32, width of cycle_count and instr_count.
- TIMEOUT, 16, maximum cycles a memory access may wait for mem_ready before an error halt (range 1 to 255).

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write.
- pc_en  output  1  PC load enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load enable.
- mdr_write  output  1  MDR load enable.
- reg_dst  output  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = reg A.
- alu_src_b  output  2  ALU B operand: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_ctl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_source  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- halted  output  1  FSM is in HALT.
- err_code  output  2  halt cause: 00 none, 01 syscall, 10 illegal instruction, 11 memory timeout.
- cycle_count  output  COUNT_W  cycles since reset, frozen while halted.
- instr_count  output  COUNT_W  retired instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - cycle_count=0, instr_count=0, err_code=00.
  - All control outputs 0, halted=0.
- Outputs decode combinationally from state. The only exceptions are pc_en, ir_write and mdr_write, which also gate on mem_ready or zero as listed. Unlisted outputs are 0 in every state.
- States and transitions:
  - IDLE: no outputs. Goes to FETCH on the next cycle.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctl=add, pc_source=00. ir_write=pc_en=mem_ready. Goes to DECODE when mem_ready=1, otherwise stays.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=add (branch target into ALUOut). Next state by opcode:
    - 0x23 or 0x2B: MEMADR.
    - 0x00: RTYPE. Exception: funct 0x0C goes to HALT with err=01.
    - 0x04: BRANCH.
    - 0x08: ADDIEX.
    - 0x02: JUMP.
    - Anything else: HALT with err=10.
  - RTYPE: alu_src_a=1, alu_src_b=00. alu_ctl from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct goes to HALT with err=10 and no writeback. Otherwise goes to RWB.
  - RWB: reg_dst=1, mem_to_reg=0, reg_write=1. Goes to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_ctl=add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read=1, iord=1, mdr_write=mem_ready. Goes to MEMWB on mem_ready, otherwise stays.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
  - MEMWR: mem_write=1, iord=1. Goes to FETCH on mem_ready, otherwise stays.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctl=sub, pc_source=01, pc_en=zero. Goes to FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctl=add. Goes to ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
  - JUMP: pc_source=10, pc_en=1. Goes to FETCH.
  - HALT: halted=1, all enables 0. Absorbing; only reset leaves it.
- Memory timeout:
  - The wait counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - It clears on mem_ready=1 and on any state change.
  - When the counter reaches TIMEOUT with mem_ready still 0, the next state is HALT with err=11.
  - The abandoned access never asserts pc_en, ir_write or mdr_write.
  - mem_ready=1 on the same cycle the counter reaches TIMEOUT counts as completion; no error.
- Counters:
  - cycle_count increments every cycle the state is not IDLE or HALT.
  - instr_count increments on each transition into FETCH from RWB, MEMWB, MEMWR, BRANCH, ADDIWB or JUMP.
  - Both wrap modulo 2^COUNT_W.
- err_code is registered on entry to HALT and held until reset.
- Reset asserted mid-instruction: all outputs drop immediately (asynchronous). No partial writeback is completed.

Test Plan:
- Reset release, mem_ready tied 1, add $t2,$t0,$t1 (0x01095020): states IDLE, FETCH, DECODE, RTYPE, RWB, FETCH. reg_write=1 and reg_dst=1 only in RWB. instr_count=1 after 5 cycles.
- lw with mem_ready low for 3 cycles in both FETCH and MEMRD: FETCH and MEMRD each held 4 cycles. ir_write and mdr_write pulse exactly once, on the ready cycle. cycle_count=11 at return to FETCH.
- beq with zero=1, then beq with zero=0: pc_en=1 with pc_source=01 in BRANCH for the first; pc_en=0 for the second. instr_count advances by 2.
- syscall (0x0000000C): halted=1 and err_code=01 one cycle after DECODE. cycle_count frozen over 20 further cycles.
- Illegal opcode 0x3F: err_code=10. Separately, funct 0x03 under opcode 0: err_code=10 with reg_write never asserted.
- mem_ready held 0 in FETCH with TIMEOUT=16: HALT with err_code=11 after 16 wait cycles, ir_write never 1. Then reset low mid-MEMWR: all outputs 0 immediately, FSM restarts at IDLE.
